// File: rtl/sa_result_drain_pkg.sv
// Shared systolic array package: result-drain state encoding and helpers.
package sa_result_drain_pkg;

  // Bit positions of the one-hot result-drain states
  localparam int DR_IDLE_B  = 0;
  localparam int DR_WAIT_B  = 1;
  localparam int DR_READ_B  = 2;
  localparam int DR_CAPT_B  = 3;
  localparam int DR_WRITE_B = 4;
  localparam int DR_FINI_B  = 5;

  typedef enum logic [5:0] {
    DR_IDLE  = 6'(1 << DR_IDLE_B),
    DR_WAIT  = 6'(1 << DR_WAIT_B),
    DR_READ  = 6'(1 << DR_READ_B),
    DR_CAPT  = 6'(1 << DR_CAPT_B),
    DR_WRITE = 6'(1 << DR_WRITE_B),
    DR_FINI  = 6'(1 << DR_FINI_B)
  } result_drain_state_t;

  // Row-select width; a single-row array still needs a one-bit select
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_result_drain_if.sv
// Write port from the result drain into the output buffer (valid/ready).
interface sa_result_drain_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int OUT_W      = 8,
  parameter int ADDR_W     = 16
);

  logic                        wr_valid;
  logic                        wr_ready;
  logic [ADDR_W-1:0]           wr_addr;
  logic [ARRAY_SIZE*OUT_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/sa_requant.sv
// One-lane requantizer: round-half-up arithmetic right shift, then saturate
// the signed accumulator value down to the signed output width.
module sa_requant #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic        [4:0]       shift,
  output logic signed [OUT_W-1:0] q_out
);

  // One guard bit so adding the rounding constant can never overflow
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] Q_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] Q_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] scaled;

  // Sign-extend, add half an LSB of the result, shift, then clamp to range
  always_comb begin
    ext = {acc_in[ACC_W-1], acc_in};
    rnd = '0;
    if (shift != 5'd0) begin
      rnd = EXT_W'(1) << (shift - 5'd1);
    end
    sum    = ext + rnd;
    scaled = sum >>> shift;
    if (scaled > Q_MAX) begin
      q_out = Q_MAX[OUT_W-1:0];
    end else if (scaled < Q_MIN) begin
      q_out = Q_MIN[OUT_W-1:0];
    end else begin
      q_out = scaled[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/sa_result_drain.sv
// Result drain: after the array finishes, reads the accumulator matrix row by
// row, requantizes every lane, writes each row to the output buffer, and then
// releases the array back to idle.
module sa_result_drain
  import sa_result_drain_pkg::*;
#(
  parameter int ARRAY_SIZE = 8,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 8,
  parameter int ADDR_W     = 16,
  localparam int ROW_W     = sel_width(ARRAY_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [4:0]                  shift,
  output logic                        busy,
  output logic                        done,
  input  logic                        sa_done,
  output logic [ROW_W-1:0]            sa_row_sel,
  input  logic [ARRAY_SIZE*ACC_W-1:0] sa_row_data,
  output logic                        sa_release,
  sa_result_drain_if.master           wr_if
);

  result_drain_state_t         state;
  logic [ROW_W-1:0]            row;
  logic [ADDR_W-1:0]           base_q;
  logic [4:0]                  shift_q;
  logic [ARRAY_SIZE*OUT_W-1:0] quant_row;

  // One requantizer per lane, all sharing the shift latched at start
  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    sa_requant #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_requant (
      .acc_in (sa_row_data[g*ACC_W +: ACC_W]),
      .shift  (shift_q),
      .q_out  (quant_row[g*OUT_W +: OUT_W])
    );
  end

  // Drain sequencer; every output is registered and set on the transition
  // into the state that owns it, so sa_row_sel is already stable in DR_READ
  // and the array answers in DR_CAPT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= DR_IDLE;
      row            <= '0;
      base_q         <= '0;
      shift_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sa_release     <= 1'b0;
      sa_row_sel     <= '0;
      wr_if.wr_valid <= 1'b0;
      wr_if.wr_addr  <= '0;
      wr_if.wr_data  <= '0;
    end else begin
      done       <= 1'b0;
      sa_release <= 1'b0;
      case (state)
        DR_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            shift_q <= shift;
            row     <= '0;
            busy    <= 1'b1;
            state   <= DR_WAIT;
          end
        end
        DR_WAIT: begin
          if (sa_done) begin
            sa_row_sel <= row;
            state      <= DR_READ;
          end
        end
        DR_READ: begin
          state <= DR_CAPT;
        end
        DR_CAPT: begin
          wr_if.wr_data  <= quant_row;
          wr_if.wr_addr  <= base_q + ADDR_W'(row);
          wr_if.wr_valid <= 1'b1;
          state          <= DR_WRITE;
        end
        DR_WRITE: begin
          if (wr_if.wr_ready) begin
            wr_if.wr_valid <= 1'b0;
            if (row == ROW_W'(ARRAY_SIZE - 1)) begin
              done       <= 1'b1;
              sa_release <= 1'b1;
              state      <= DR_FINI;
            end else begin
              row        <= row + 1'b1;
              sa_row_sel <= row + 1'b1;
              state      <= DR_READ;
            end
          end
        end
        DR_FINI: begin
          busy  <= 1'b0;
          state <= DR_IDLE;
        end
        default: begin
          busy           <= 1'b0;
          wr_if.wr_valid <= 1'b0;
          state          <= DR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain with a 4x4 array, hand-computed rows.
module tb_sa_result_drain;

  localparam int N      = 4;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 8;
  localparam int ADDR_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic [4:0]            shift;
  logic                  busy;
  logic                  done;
  logic                  sa_done;
  logic [1:0]            sa_row_sel;
  logic [N*ACC_W-1:0]    sa_row_data;
  logic                  sa_release;
  logic [N*ACC_W-1:0]    row_mem [N];

  int checks_total  = 0;
  int checks_passed = 0;
  int cycle         = 0;
  int n_writes      = 0;
  int done_count    = 0;
  int release_count = 0;
  int done_cycle    = 0;
  int release_cycle = 0;
  int done_before   = 0;
  int release_before = 0;
  int t_sa          = 0;
  logic [ADDR_W-1:0]  wr_addr_log  [8];
  logic [N*OUT_W-1:0] wr_data_log  [8];
  int                 wr_cycle_log [8];

  sa_result_drain_if #(.ARRAY_SIZE(N), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) wr_bus ();

  sa_result_drain #(
    .ARRAY_SIZE (N),
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .shift       (shift),
    .busy        (busy),
    .done        (done),
    .sa_done     (sa_done),
    .sa_row_sel  (sa_row_sel),
    .sa_row_data (sa_row_data),
    .sa_release  (sa_release),
    .wr_if       (wr_bus.master)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency checks
  always @(posedge clk) cycle <= cycle + 1;

  // Array model: row contents appear the cycle after the select
  always @(posedge clk) sa_row_data <= row_mem[sa_row_sel];

  // Mid-cycle monitor logging accepted writes and done/release pulses
  always @(negedge clk) begin
    if (wr_bus.wr_valid && wr_bus.wr_ready) begin
      if (n_writes < 8) begin
        wr_addr_log[n_writes]  = wr_bus.wr_addr;
        wr_data_log[n_writes]  = wr_bus.wr_data;
        wr_cycle_log[n_writes] = cycle;
      end
      n_writes++;
    end
    if (done) begin
      done_count++;
      done_cycle = cycle;
    end
    if (sa_release) begin
      release_count++;
      release_cycle = cycle;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [N*ACC_W-1:0] pack_row(input int l0, input int l1,
                                                  input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic load_rows(input logic [N*ACC_W-1:0] r0, input logic [N*ACC_W-1:0] r1,
                           input logic [N*ACC_W-1:0] r2, input logic [N*ACC_W-1:0] r3);
    row_mem[0] = r0;
    row_mem[1] = r1;
    row_mem[2] = r2;
    row_mem[3] = r3;
  endtask

  task automatic load_basic();
    load_rows(pack_row(1, 2, 3, 4), pack_row(5, 6, 7, 8),
              pack_row(9, 10, 11, 12), pack_row(13, 14, 15, 16));
  endtask

  // Start a drain, release it with sa_done, serve writes with optional stalls
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [4:0] sh,
                               input int stall, input bit pre_sa_done,
                               input bit second_start);
    int budget;
    int stall_cnt;
    bit prev_stalled;
    logic [ADDR_W-1:0]  held_addr;
    logic [N*OUT_W-1:0] held_data;
    n_writes       = 0;
    done_before    = done_count;
    release_before = release_count;
    wr_bus.wr_ready = 1'b1;
    held_addr = '0;
    held_data = '0;
    if (pre_sa_done) begin
      sa_done = 1'b1;
      tick();
      sa_done = 1'b0;
      tick();
    end
    base_addr = base;
    shift     = sh;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = '0;
    shift     = '0;
    checkOutput("busy_after_start", busy, 1);
    for (int i = 0; i < 3; i++) begin
      if (second_start && i == 1) begin
        start     = 1'b1;
        base_addr = 16'h5555;
        shift     = 5'd7;
      end else begin
        start     = 1'b0;
        base_addr = '0;
        shift     = '0;
      end
      tick();
    end
    start     = 1'b0;
    base_addr = '0;
    shift     = '0;
    checkOutput("no_write_before_sa_done", n_writes, 0);
    checkOutput("no_valid_before_sa_done", wr_bus.wr_valid, 0);
    sa_done = 1'b1;
    t_sa    = cycle;
    tick();
    sa_done = 1'b0;
    budget = 0;
    stall_cnt = 0;
    prev_stalled = 1'b0;
    while (done_count == done_before && budget < 300) begin
      if (prev_stalled) begin
        checkOutput("stall_valid_held", wr_bus.wr_valid, 1);
        checkOutput("stall_addr_held", wr_bus.wr_addr, held_addr);
        checkOutput("stall_data_held", wr_bus.wr_data, held_data);
      end
      if (wr_bus.wr_valid) begin
        held_addr       = wr_bus.wr_addr;
        held_data       = wr_bus.wr_data;
        prev_stalled    = (stall_cnt < stall);
        wr_bus.wr_ready = !prev_stalled;
        stall_cnt++;
      end else begin
        prev_stalled    = 1'b0;
        stall_cnt       = 0;
        wr_bus.wr_ready = 1'b1;
      end
      tick();
      budget++;
    end
    wr_bus.wr_ready = 1'b1;
    checkOutput("drain_done_seen", done_count - done_before, 1);
    checkOutput("busy_clear_after_done", busy, 0);
    tick();
    tick();
  endtask

  // Compare the logged drain against hand-computed addresses, data and timing
  task automatic checkRun(input string tag, input logic [ADDR_W-1:0] base,
                          input int stall, input int done_lat,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp_data [N];
    exp_data = '{e0, e1, e2, e3};
    checkOutput({tag, "_write_count"}, n_writes, N);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr_log[i], ADDR_W'(base + i));
      checkOutput($sformatf("%s_data%0d", tag, i), wr_data_log[i], exp_data[i]);
      checkOutput($sformatf("%s_wcycle%0d", tag, i), wr_cycle_log[i] - t_sa,
                  3 + stall + i * (3 + stall));
    end
    checkOutput({tag, "_done_pulses"}, done_count - done_before, 1);
    checkOutput({tag, "_release_pulses"}, release_count - release_before, 1);
    checkOutput({tag, "_done_latency"}, done_cycle - t_sa, done_lat);
    checkOutput({tag, "_release_latency"}, release_cycle - t_sa, done_lat);
  endtask

  initial begin
    int budget;
    int rel_snap;
    rst             = 1'b1;
    start           = 1'b0;
    sa_done         = 1'b0;
    base_addr       = '0;
    shift           = '0;
    wr_bus.wr_ready = 1'b1;
    load_basic();
    tick();
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wr_valid", wr_bus.wr_valid, 0);
    checkOutput("rst_wr_addr", wr_bus.wr_addr, 0);
    checkOutput("rst_wr_data", wr_bus.wr_data, 0);
    checkOutput("rst_row_sel", sa_row_sel, 0);
    checkOutput("rst_release", sa_release, 0);
    rst = 1'b0;
    tick();

    $display("[TB] basic drain");
    load_basic();
    applyStimulus(16'h0100, 5'd0, 0, 1'b0, 1'b0);
    checkRun("basic", 16'h0100, 0, 13,
             32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);

    $display("[TB] rounding");
    load_rows(pack_row(24, 23, -24, -25),
              pack_row(8, 7, -8, 32'h7FFFFFFF),
              pack_row(32'h80000000, 2032, 2039, -2048),
              pack_row(0, -8, -9, 2024));
    applyStimulus(16'h0010, 5'd4, 0, 1'b0, 1'b0);
    checkRun("round", 16'h0010, 0, 13,
             32'hFEFF0102, 32'h7F000001, 32'h807F7F80, 32'h7FFF0000);

    $display("[TB] saturation");
    load_rows(pack_row(300, -300, 127, -128),
              pack_row(128, -129, 32'h7FFFFFFF, 32'h80000000),
              pack_row(126, -127, -1, 1),
              pack_row(0, 0, 0, 0));
    applyStimulus(16'h0020, 5'd0, 0, 1'b0, 1'b0);
    checkRun("sat", 16'h0020, 0, 13,
             32'h807F807F, 32'h807F807F, 32'h01FF817E, 32'h00000000);

    $display("[TB] backpressure and address wrap");
    load_basic();
    applyStimulus(16'hFFFE, 5'd0, 3, 1'b0, 1'b0);
    checkRun("stall", 16'hFFFE, 3, 25,
             32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);

    $display("[TB] early sa_done and start while busy");
    applyStimulus(16'h0200, 5'd0, 0, 1'b1, 1'b1);
    checkRun("proto", 16'h0200, 0, 13,
             32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);

    $display("[TB] reset during row 2 write");
    n_writes  = 0;
    rel_snap  = release_count;
    base_addr = 16'h0300;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = '0;
    sa_done   = 1'b1;
    tick();
    sa_done   = 1'b0;
    budget    = 0;
    while (!(wr_bus.wr_valid && n_writes == 2) && budget < 100) begin
      tick();
      budget++;
    end
    checkOutput("rst_reached_row2", (wr_bus.wr_valid && n_writes == 2), 1);
    wr_bus.wr_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_bus.wr_ready = 1'b1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_wr_valid", wr_bus.wr_valid, 0);
    checkOutput("midrst_wr_addr", wr_bus.wr_addr, 0);
    checkOutput("midrst_wr_data", wr_bus.wr_data, 0);
    checkOutput("midrst_row_sel", sa_row_sel, 0);
    checkOutput("midrst_release", sa_release, 0);
    tick();
    tick();
    tick();
    checkOutput("midrst_write_count", n_writes, 2);
    checkOutput("midrst_no_release", release_count - rel_snap, 0);
    checkOutput("midrst_stays_idle", busy, 0);
    applyStimulus(16'h0400, 5'd0, 0, 1'b0, 1'b0);
    checkRun("redrain", 16'h0400, 0, 13,
             32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/sa_result_drain.md
# sa_result_drain

Read-side counterpart of the systolic array controller. Once the array reaches its finish state (`sa_done`), this block reads the accumulator matrix one row at a time, requantizes each lane from ACC_W to OUT_W, and writes each row to the output buffer over a valid/ready port. It then pulses `sa_release` so the array can leave its finish state and return to idle. It sits between the systolic array and the output SRAM and is started by the top-level sequencer.

## Interface
Parameters:
- ARRAY_SIZE, 8, rows/lanes of the array (N); ≥1
- ACC_W, 32, signed accumulator width per lane
- OUT_W, 8, signed output width per lane; OUT_W < ACC_W
- ADDR_W, 16, output buffer address width

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in DR_IDLE
- base_addr  in  ADDR_W  output address of row 0; latched on accepted start
- shift  in  5  right-shift amount; latched on accepted start
- busy  out  1  high in every state except DR_IDLE
- done  out  1  one-cycle pulse in DR_FINI
- sa_done  in  1  array has reached its finish state; level or pulse
- sa_row_sel  out  $clog2(ARRAY_SIZE) (min 1)  row to read
- sa_row_data  in  ARRAY_SIZE*ACC_W  row contents, valid the cycle after sa_row_sel is presented; lane 0 in LSBs
- sa_release  out  1  one-cycle pulse in DR_FINI; results consumed
- wr_valid  out  1  write request
- wr_ready  in  1  buffer accepts write when wr_valid && wr_ready
- wr_addr  out  ADDR_W  write address
- wr_data  out  ARRAY_SIZE*OUT_W  requantized row; lane 0 in LSBs

## Operation
- FSM, one-hot: DR_IDLE, DR_WAIT, DR_READ, DR_CAPT, DR_WRITE, DR_FINI.
- DR_IDLE: if start, latch base_addr and shift, clear the row counter, go to DR_WAIT. sa_done is ignored here and is not remembered.
- DR_WAIT: hold until sa_done is high, then go to DR_READ.
- DR_READ: drive sa_row_sel = row counter, then go to DR_CAPT.
- DR_CAPT: sa_row_data is valid. Register the requantized lanes into wr_data and set wr_addr = base_addr + row (mod 2^ADDR_W). Go to DR_WRITE.
- DR_WRITE: wr_valid is high. wr_data and wr_addr stay stable until the write is accepted. On acceptance, if row == N-1 go to DR_FINI; otherwise increment the row counter and go to DR_READ.
- DR_FINI: done = 1 and sa_release = 1 for exactly one cycle, then DR_IDLE.
- Requantization, per lane, signed:
  - If shift > 0, s = (x + 2^(shift-1)) >>> shift; the addition is done at ACC_W+1 bits so it cannot overflow.
  - If shift == 0, s = x.
  - s is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- start while busy is ignored.
- sa_row_sel holds its last value outside DR_READ.

## Timing
- Reset values: busy=0, done=0, wr_valid=0, wr_addr=0, wr_data=0, sa_row_sel=0, sa_release=0; state DR_IDLE; row counter 0.
- start high at cycle c (in DR_IDLE): DR_WAIT at c+1, busy=1 from c+1.
- sa_done seen at cycle t (in DR_WAIT): DR_READ t+1, DR_CAPT t+2, wr_valid=1 at t+3.
- Each row takes 3 cycles when wr_ready is held high. Each cycle wr_ready is low adds one cycle.
- With wr_ready always high, done and sa_release pulse at cycle t+1+3N and busy=0 from t+2+3N.
- wr_valid never drops without acceptance. The only exception is rst.
- rst mid-operation: next cycle is DR_IDLE with all reset values; no sa_release pulse. The array is not released, and the sequencer re-issues start.

## Structure
- Add to the shared systolic array package:
  - bit indices DR_IDLE_B..DR_FINI_B (0..5)
  - one-hot enum `result_drain_state_t` (logic [5:0]), defined in the same style as the array's state enum
- Sub-module `sa_requant`: combinational round/shift/saturate of one lane, parameterized by ACC_W and OUT_W. It is instantiated ARRAY_SIZE times in a generate loop.
- Requantization width constants stay local parameters of `sa_requant`.

## Test plan
All tests use N=4, ACC_W=32, OUT_W=8, ADDR_W=16.
- Basic drain: shift=0, rows contain lane values 1..16, base_addr=0x0100, wr_ready=1 -> 4 writes at 0x0100..0x0103 with exact values, each 3 cycles apart; done and sa_release pulse once at t+13.
- Rounding: shift=4, lanes {24, 23, -24, -25} -> {2, 1, -1, -2} (round half up: 24→2, -24→-1).
- Saturation: shift=0, lanes {300, -300, 127, -128} -> {127, -128, 127, -128}.
- Backpressure and address wrap: base_addr=0xFFFE, wr_ready low for 3 cycles on each write -> wr_valid, wr_addr and wr_data stay stable while stalled; addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001; done arrives 12 cycles later than the no-stall case.
- Protocol edges: sa_done pulsed in DR_IDLE before start -> no read until a new sa_done arrives in DR_WAIT; a second start during busy is ignored (still exactly 4 writes).
- Reset mid-row: assert rst in DR_WRITE of row 2 -> next cycle all outputs are at reset values, no sa_release; a later start drains all 4 rows again from row 0.
